axi_aw_arbiter_n: RTL and testbench

AXI_AW_ARBITER_N -- requirements
Module: axi_aw_arbiter_n

---
 rtl/axi_arb_pkg.sv | 13 +
 rtl/arb_rr_picker.sv | 37 +++
 rtl/axi_aw_arbiter_n.sv | 105 ++++++++++
 tb/tb_axi_aw_arbiter_n.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared constants for the AXI arbiters: policy selectors and the grant FSM encoding.
package axi_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_rr_picker.sv
// Masked priority encoder: lowest asserted req bit at or above ptr, else lowest overall.
module arb_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick_src;
    logic         hit;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        mask     = '0;
        onehot   = '0;
        idx      = '0;
        hit      = 1'b0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked   = req & mask;
        pick_src = (|masked) ? masked : req;
        for (int i = 0; i < N; i++) begin
            if (!hit && pick_src[i]) begin
                hit       = 1'b1;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_aw_arbiter_n.sv
// AW-channel arbiter: grants one master per burst and holds it until WLAST completes.
module axi_aw_arbiter_n
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = ARB_RR,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [NUM_MASTERS-1:0] awvalid_in,
    input  logic                   Channel_Granted,
    input  logic                   aw_hs,
    input  logic                   w_last_hs,
    output logic                   Channel_Request,
    output logic                   grant_valid,
    output logic [NUM_MASTERS-1:0] grant_onehot,
    output logic [IDX_W-1:0]       Selected_Master,
    output logic                   w_route_valid
);

    arb_state_e             state_q;
    arb_state_e             state_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       sel_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       pick_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic                   any_req;

    assign any_req  = |awvalid_in;
    assign pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    arb_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (awvalid_in),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge ACLK) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Channel_Granted && any_req) state_d = ST_ADDR;
            ST_ADDR: if (aw_hs) state_d = w_last_hs ? ST_IDLE : ST_DATA;
            ST_DATA: if (w_last_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Channel_Request = 1'b0;
        grant_valid     = 1'b0;
        grant_onehot    = '0;
        w_route_valid   = 1'b0;
        case (state_q)
            ST_IDLE: Channel_Request = !ARESET && Channel_Granted && any_req;
            ST_ADDR: begin
                grant_valid   = 1'b1;
                grant_onehot  = grant_q;
                w_route_valid = aw_hs;
            end
            ST_DATA: begin
                grant_valid   = 1'b1;
                grant_onehot  = grant_q;
                w_route_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign Selected_Master = sel_q;

    // Winner is captured only on IDLE->ADDR; the pointer advances past it once its AW is accepted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            grant_q  <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_ADDR) begin
                grant_q <= pick_onehot;
                sel_q   <= pick_idx;
            end
            if (ARB_MODE == ARB_RR && state_q == ST_ADDR && aw_hs) begin
                rr_ptr_q <= (sel_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_aw_arbiter_n.sv
// Bench for axi_aw_arbiter_n: fixed and round-robin instances share stimulus and a reference model.
module tb_axi_aw_arbiter_n;

    localparam int N = 4;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic [3:0] awvalid_in = '0;
    logic       Channel_Granted = 1'b0;
    logic       aw_hs = 1'b0;
    logic       w_last_hs = 1'b0;

    // Index 0 = fixed-priority instance, index 1 = round-robin instance.
    logic       cr  [2];
    logic       gv  [2];
    logic [3:0] oh  [2];
    logic [1:0] sel [2];
    logic       wr  [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = IDLE, 1 = ADDR, 2 = DATA.
    int m_st  [2] = '{0, 0};
    int m_sel [2] = '{0, 0};
    int m_ptr [2] = '{0, 0};

    always #5 ACLK = ~ACLK;

    axi_aw_arbiter_n #(.NUM_MASTERS(N), .ARB_MODE(0)) dut_fx (
        .ACLK(ACLK), .ARESET(ARESET), .awvalid_in(awvalid_in),
        .Channel_Granted(Channel_Granted), .aw_hs(aw_hs), .w_last_hs(w_last_hs),
        .Channel_Request(cr[0]), .grant_valid(gv[0]), .grant_onehot(oh[0]),
        .Selected_Master(sel[0]), .w_route_valid(wr[0])
    );

    axi_aw_arbiter_n #(.NUM_MASTERS(N), .ARB_MODE(1)) dut_rr (
        .ACLK(ACLK), .ARESET(ARESET), .awvalid_in(awvalid_in),
        .Channel_Granted(Channel_Granted), .aw_hs(aw_hs), .w_last_hs(w_last_hs),
        .Channel_Request(cr[1]), .grant_valid(gv[1]), .grant_onehot(oh[1]),
        .Selected_Master(sel[1]), .w_route_valid(wr[1])
    );

    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int c = (start + k) % N;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    task automatic drive(input logic r, input logic [3:0] v, input logic cg,
                         input logic aw, input logic wl);
        ARESET          = r;
        awvalid_in      = v;
        Channel_Granted = cg;
        aw_hs           = aw;
        w_last_hs       = wl;
        #1;
    endtask

    task automatic tick();
        for (int m = 0; m < 2; m++) begin
            if (ARESET) begin
                m_st[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
            end else if (m_st[m] == 0) begin
                if (Channel_Granted && |awvalid_in) begin
                    m_sel[m] = pick(awvalid_in, (m == 1) ? m_ptr[m] : 0);
                    m_st[m]  = 1;
                end
            end else if (m_st[m] == 1) begin
                if (aw_hs) begin
                    if (m == 1) m_ptr[m] = (m_sel[m] + 1) % N;
                    m_st[m] = w_last_hs ? 0 : 2;
                end
            end else if (w_last_hs) begin
                m_st[m] = 0;
            end
        end
        @(posedge ACLK);
        @(negedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (cr[m] !== 1'b0) $display("FAIL reset_req[%0d]: got %0b need 0", m, cr[m]); else n_pass++;
            n_checks++; if (gv[m] !== 1'b0) $display("FAIL reset_gv[%0d]: got %0b need 0", m, gv[m]); else n_pass++;
            n_checks++; if (oh[m] !== 4'b0000) $display("FAIL reset_onehot[%0d]: got %b need 0000", m, oh[m]); else n_pass++;
            n_checks++; if (sel[m] !== 2'd0) $display("FAIL reset_sel[%0d]: got %0d need 0", m, sel[m]); else n_pass++;
        end
        drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (cr[m] !== 1'b1) $display("FAIL post_reset_req[%0d]: got %0b need 1", m, cr[m]); else n_pass++;
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (gv[m] !== 1'b1) $display("FAIL first_grant_gv[%0d]: got %0b need 1", m, gv[m]); else n_pass++;
            n_checks++; if (oh[m] !== 4'b0001) $display("FAIL first_grant_oh[%0d]: got %b need 0001", m, oh[m]); else n_pass++;
        end
    endtask

    task automatic test_rr_rotation();
        do_reset();
        drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_oh;
            exp_oh = 4'b0001 << (k % N);
            n_checks++; if (sel[1] !== 2'(k % N)) $display("FAIL rr_seq_sel[%0d]: got %0d need %0d", k, sel[1], k % N); else n_pass++;
            n_checks++; if (oh[1] !== exp_oh) $display("FAIL rr_seq_oh[%0d]: got %b need %b", k, oh[1], exp_oh); else n_pass++;
            n_checks++; if (sel[0] !== 2'd0) $display("FAIL fixed_seq_sel[%0d]: got %0d need 0", k, sel[0]); else n_pass++;
            drive(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1);
            tick();
            drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
            n_checks++; if (gv[1] !== 1'b0) $display("FAIL rr_idle_gap[%0d]: got %0b need 0", k, gv[1]); else n_pass++;
            tick();
        end
    endtask

    task automatic test_fixed();
        do_reset();
        drive(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (sel[0] !== 2'd1) $display("FAIL fixed_first_sel: got %0d need 1", sel[0]); else n_pass++;
        n_checks++; if (oh[0] !== 4'b0010) $display("FAIL fixed_first_oh: got %b need 0010", oh[0]); else n_pass++;
        drive(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1);
        n_checks++; if (wr[0] !== 1'b1) $display("FAIL fixed_data_route: got %0b need 1", wr[0]); else n_pass++;
        tick();
        drive(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gv[0] !== 1'b0) $display("FAIL fixed_idle: got %0b need 0", gv[0]); else n_pass++;
        tick();
        n_checks++; if (sel[0] !== 2'd1) $display("FAIL fixed_second_sel: got %0d need 1", sel[0]); else n_pass++;
        n_checks++; if (sel[1] !== 2'd3) $display("FAIL rr_second_sel: got %0d need 3", sel[1]); else n_pass++;
    endtask

    task automatic test_long_burst();
        do_reset();
        drive(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            // Requests and channel permission change mid-burst; the grant must not move.
            drive(1'b0, 4'b0001, 1'b0, (c == 0), (c == 3));
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (wr[m] !== 1'b1) $display("FAIL burst_route[%0d][%0d]: got %0b need 1", m, c, wr[m]); else n_pass++;
                n_checks++; if (oh[m] !== 4'b0100) $display("FAIL burst_oh[%0d][%0d]: got %b need 0100", m, c, oh[m]); else n_pass++;
                n_checks++; if (sel[m] !== 2'd2) $display("FAIL burst_sel[%0d][%0d]: got %0d need 2", m, c, sel[m]); else n_pass++;
            end
            tick();
        end
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (gv[m] !== 1'b0) $display("FAIL burst_end_gv[%0d]: got %0b need 0", m, gv[m]); else n_pass++;
            n_checks++; if (wr[m] !== 1'b0) $display("FAIL burst_end_route[%0d]: got %0b need 0", m, wr[m]); else n_pass++;
            n_checks++; if (oh[m] !== 4'b0000) $display("FAIL burst_end_oh[%0d]: got %b need 0000", m, oh[m]); else n_pass++;
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        drive(1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b0011, 1'b1, 1'b1, 1'b1);
        n_checks++; if (wr[1] !== 1'b1) $display("FAIL single_route: got %0b need 1", wr[1]); else n_pass++;
        tick();
        drive(1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gv[1] !== 1'b0) $display("FAIL single_idle: got %0b need 0", gv[1]); else n_pass++;
        tick();
        n_checks++; if (sel[1] !== 2'd1) $display("FAIL single_rr_adv: got %0d need 1", sel[1]); else n_pass++;
        n_checks++; if (sel[0] !== 2'd0) $display("FAIL single_fixed: got %0d need 0", sel[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'b1000, 1'b1, 1'b0, 1'b0);
        n_checks++; if (gv[1] !== 1'b1) $display("FAIL midrst_data_gv: got %0b need 1", gv[1]); else n_pass++;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (gv[m] !== 1'b0) $display("FAIL midrst_gv[%0d]: got %0b need 0", m, gv[m]); else n_pass++;
            n_checks++; if (sel[m] !== 2'd0) $display("FAIL midrst_sel[%0d]: got %0d need 0", m, sel[m]); else n_pass++;
        end
        drive(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (sel[1] !== 2'd3) $display("FAIL midrst_regrant: got %0d need 3", sel[1]); else n_pass++;
        n_checks++; if (oh[1] !== 4'b1000) $display("FAIL midrst_regrant_oh: got %b need 1000", oh[1]); else n_pass++;
        // Advance the pointer to 2, reset in DATA, and confirm arbitration restarts from M0.
        do_reset();
        drive(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b0010, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (sel[1] !== 2'd0) $display("FAIL midrst_ptr_clear: got %0d need 0", sel[1]); else n_pass++;
    endtask

    task automatic test_channel_gate();
        do_reset();
        drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        n_checks++; if (cr[1] !== 1'b0) $display("FAIL gate_req_low: got %0b need 0", cr[1]); else n_pass++;
        tick();
        tick();
        n_checks++; if (gv[1] !== 1'b0) $display("FAIL gate_no_grant: got %0b need 0", gv[1]); else n_pass++;
        drive(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        n_checks++; if (cr[1] !== 1'b1) $display("FAIL gate_req_high: got %0b need 1", cr[1]); else n_pass++;
        tick();
        n_checks++; if (gv[1] !== 1'b1) $display("FAIL gate_grant: got %0b need 1", gv[1]); else n_pass++;
        n_checks++; if (sel[1] !== 2'd0) $display("FAIL gate_sel: got %0d need 0", sel[1]); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            for (int m = 0; m < 2; m++) begin
                logic       e_cr, e_gv, e_wr;
                logic [3:0] e_oh;
                e_cr = (m_st[m] == 0) && !ARESET && Channel_Granted && (|awvalid_in);
                e_gv = (m_st[m] != 0);
                e_wr = (m_st[m] == 2) || (m_st[m] == 1 && aw_hs);
                e_oh = e_gv ? (4'b0001 << m_sel[m]) : 4'b0000;
                n_checks++; if (cr[m] !== e_cr) $display("FAIL rnd_req[%0d] @%0d: got %0b need %0b", m, i, cr[m], e_cr); else n_pass++;
                n_checks++; if (gv[m] !== e_gv) $display("FAIL rnd_gv[%0d] @%0d: got %0b need %0b", m, i, gv[m], e_gv); else n_pass++;
                n_checks++; if (wr[m] !== e_wr) $display("FAIL rnd_route[%0d] @%0d: got %0b need %0b", m, i, wr[m], e_wr); else n_pass++;
                n_checks++; if (oh[m] !== e_oh) $display("FAIL rnd_oh[%0d] @%0d: got %b need %b", m, i, oh[m], e_oh); else n_pass++;
                n_checks++; if (sel[m] !== 2'(m_sel[m])) $display("FAIL rnd_sel[%0d] @%0d: got %0d need %0d", m, i, sel[m], m_sel[m]); else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        @(negedge ACLK);
        test_reset();
        test_rr_rotation();
        test_fixed();
        test_long_burst();
        test_single_beat();
        test_reset_mid_burst();
        test_channel_gate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
